// File: rtl/cam_pkg.sv
// Shared types and constants for the CAM request controller.
package cam_pkg;

    localparam int unsigned KEY_W = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    // Reserved key parked in free slots so a scrubbed entry never matches a real request.
    localparam logic [KEY_W-1:0] EMPTY_KEY = 8'hFF;

    typedef enum logic [1:0] {
        OpLookup = 2'b00,
        OpInsert = 2'b01,
        OpDelete = 2'b10,
        OpRsvd   = 2'b11
    } cam_op_e;

    typedef enum logic [1:0] {
        StsOk   = 2'b00,
        StsMiss = 2'b01,
        StsFull = 2'b10,
        StsErr  = 2'b11
    } cam_status_e;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StSearch,
        StWait,
        StWrite,
        StResp
    } cam_state_e;

endpackage

// File: rtl/cam_free_slot_enc.sv
// Finds the lowest-index free slot in the occupancy bitmap.
module cam_free_slot_enc
    import cam_pkg::*;
(
    input  logic [DEPTH-1:0] valid_map,
    output logic [IDX_W-1:0] free_idx,
    output logic             none_free
);

    // Scan from the top down so the lowest clear bit is the last one to win.
    always_comb begin
        free_idx  = '0;
        none_free = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_map[i]) begin
                free_idx  = IDX_W'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// Initiator-side controller for a 16x8 CAM: scrub after reset, then serve
// lookup/insert/delete requests one at a time with slot occupancy tracking.
module cam_ctrl
    import cam_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [KEY_W-1:0] req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic [IDX_W-1:0] rsp_index,
    output logic             cam_wen,
    output logic             cam_ren,
    output logic [KEY_W-1:0] cam_din,
    output logic [IDX_W-1:0] cam_addr,
    input  logic [IDX_W-1:0] cam_dout,
    input  logic             cam_hit,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    cam_state_e       state_q;
    cam_op_e          op_q;
    logic [KEY_W-1:0] key_q;
    logic [IDX_W-1:0] init_cnt_q;
    logic [DEPTH-1:0] valid_map_q;
    logic [IDX_W-1:0] free_idx;
    logic             none_free;

    cam_free_slot_enc u_free_slot_enc (
        .valid_map (valid_map_q),
        .free_idx  (free_idx),
        .none_free (none_free)
    );

    assign full = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StInit;
            op_q        <= OpLookup;
            key_q       <= '0;
            init_cnt_q  <= '0;
            valid_map_q <= '0;
            count       <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_status  <= '0;
            rsp_index   <= '0;
            cam_wen     <= 1'b0;
            cam_ren     <= 1'b0;
            cam_din     <= '0;
            cam_addr    <= '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    // cam_wen low marks the very first scrub cycle after reset.
                    if (cam_wen && cam_addr == IDX_W'(DEPTH - 1)) begin
                        cam_wen   <= 1'b0;
                        cam_addr  <= '0;
                        cam_din   <= '0;
                        req_ready <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        cam_wen    <= 1'b1;
                        cam_addr   <= init_cnt_q;
                        cam_din    <= EMPTY_KEY;
                        init_cnt_q <= init_cnt_q + IDX_W'(1);
                    end
                end
                StIdle: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= cam_op_e'(req_op);
                        key_q     <= req_key;
                        if (req_op == OpRsvd || req_key == EMPTY_KEY) begin
                            rsp_valid  <= 1'b1;
                            rsp_status <= StsErr;
                            rsp_index  <= '0;
                            state_q    <= StResp;
                        end else begin
                            cam_ren <= 1'b1;
                            cam_din <= req_key;
                            state_q <= StSearch;
                        end
                    end
                end
                StSearch: begin
                    cam_ren <= 1'b0;
                    cam_din <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    rsp_status <= StsOk;
                    rsp_index  <= '0;
                    rsp_valid  <= 1'b1;
                    state_q    <= StResp;
                    unique case (op_q)
                        OpLookup: begin
                            if (cam_hit) rsp_index <= cam_dout;
                            else         rsp_status <= StsMiss;
                        end
                        OpInsert: begin
                            // Duplicate check comes before the full check.
                            if (cam_hit) begin
                                rsp_index <= cam_dout;
                            end else if (none_free) begin
                                rsp_status <= StsFull;
                            end else begin
                                rsp_valid              <= 1'b0;
                                state_q                <= StWrite;
                                cam_wen                <= 1'b1;
                                cam_addr               <= free_idx;
                                cam_din                <= key_q;
                                valid_map_q[free_idx]  <= 1'b1;
                                count                  <= count + CNT_W'(1);
                                rsp_index              <= free_idx;
                            end
                        end
                        OpDelete: begin
                            if (cam_hit) begin
                                rsp_valid             <= 1'b0;
                                state_q               <= StWrite;
                                cam_wen               <= 1'b1;
                                cam_addr              <= cam_dout;
                                cam_din               <= EMPTY_KEY;
                                valid_map_q[cam_dout] <= 1'b0;
                                if (valid_map_q[cam_dout]) count <= count - CNT_W'(1);
                                rsp_index             <= cam_dout;
                            end else begin
                                rsp_status <= StsMiss;
                            end
                        end
                        default: rsp_status <= StsErr;
                    endcase
                end
                StWrite: begin
                    cam_wen   <= 1'b0;
                    cam_addr  <= '0;
                    cam_din   <= '0;
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_status <= '0;
                        rsp_index  <= '0;
                        req_ready  <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural registered CAM attached.
module tb_cam_ctrl;
    import cam_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_key = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_status;
    logic [3:0] rsp_index;
    logic       cam_wen;
    logic       cam_ren;
    logic [7:0] cam_din;
    logic [3:0] cam_addr;
    logic [3:0] cam_dout = 4'h0;
    logic       cam_hit = 1'b0;
    logic [4:0] count;
    logic       full;

    logic [7:0] mem [16];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cam_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_key    (req_key),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_index  (rsp_index),
        .cam_wen    (cam_wen),
        .cam_ren    (cam_ren),
        .cam_din    (cam_din),
        .cam_addr   (cam_addr),
        .cam_dout   (cam_dout),
        .cam_hit    (cam_hit),
        .count      (count),
        .full       (full)
    );

    // Registered CAM: lowest matching index wins, result one cycle after ren.
    always @(posedge clk) begin
        if (cam_wen) mem[cam_addr] <= cam_din;
        if (cam_ren) begin
            cam_hit  <= 1'b0;
            cam_dout <= 4'h0;
            for (int i = 15; i >= 0; i--) begin
                if (mem[4'(i)] == cam_din) begin
                    cam_hit  <= 1'b1;
                    cam_dout <= 4'(i);
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 32'({req_ready, rsp_valid, rsp_status, rsp_index, cam_wen, cam_ren,
                           cam_din, cam_addr, count, full}), 32'(0));
    endtask

    // Call with rst_n already high and the next edge being the first high edge.
    task automatic scrub_check();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            check_eq("scrub wen/ren/addr/din", 32'({cam_wen, cam_ren, cam_addr, cam_din}),
                     32'({1'b1, 1'b0, 4'(i), 8'hFF}));
            check_eq("scrub no rsp/ready", 32'({rsp_valid, req_ready}), 32'(0));
        end
        @(posedge clk); #1;
        check_eq("ready after scrub", 32'({req_ready, cam_wen, cam_ren}), 32'(3'b100));
        check_eq("count after scrub", 32'({count, full}), 32'(0));
    endtask

    task automatic do_req(input logic [1:0] op, input logic [7:0] key, input logic [1:0] exp_sts,
                          input logic [3:0] exp_idx, input int exp_lat, input logic [1:0] exp_acc,
                          input int hold);
        int         lat;
        logic [1:0] acc;
        logic       rr_seen;
        lat = 0;
        while (!req_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("req_ready before accept", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_key   = 8'h00;
        lat     = 1;
        acc     = 2'b00;
        rr_seen = 1'b0;
        while (!rsp_valid && lat < 20) begin
            acc     |= {cam_wen, cam_ren};
            rr_seen |= req_ready;
            @(posedge clk); #1;
            lat++;
        end
        acc     |= {cam_wen, cam_ren};
        rr_seen |= req_ready;
        check_eq("rsp latency", 32'(lat), 32'(exp_lat));
        check_eq("rsp status", 32'(rsp_status), 32'(exp_sts));
        check_eq("rsp index", 32'(rsp_index), 32'(exp_idx));
        check_eq("cam access {wen,ren}", 32'(acc), 32'(exp_acc));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            rr_seen |= req_ready;
            check_eq("held rsp fields", 32'({rsp_valid, rsp_status, rsp_index}),
                     32'({1'b1, exp_sts, exp_idx}));
        end
        check_eq("req_ready low in flight", 32'(rr_seen), 32'(0));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("rsp_valid drops after handshake", 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("outputs in reset");
        rst_n = 1'b1;
        scrub_check();

        do_req(2'b01, 8'h3C, 2'b00, 4'd0, 4, 2'b11, 0);
        check_eq("count after first insert", 32'({count, full}), 32'({5'd1, 1'b0}));
        do_req(2'b00, 8'h3C, 2'b00, 4'd0, 3, 2'b01, 0);
        do_req(2'b00, 8'h55, 2'b01, 4'd0, 3, 2'b01, 0);
        do_req(2'b01, 8'h3C, 2'b00, 4'd0, 3, 2'b01, 0);
        check_eq("count after dup insert", 32'(count), 32'(1));

        for (int i = 1; i < 16; i++) begin
            do_req(2'b01, 8'h10 + 8'(i), 2'b00, 4'(i), 4, 2'b11, 0);
        end
        check_eq("count/full when full", 32'({count, full}), 32'({5'd16, 1'b1}));
        do_req(2'b01, 8'h77, 2'b10, 4'd0, 3, 2'b01, 0);
        check_eq("count after FULL", 32'(count), 32'(16));
        do_req(2'b10, 8'h15, 2'b00, 4'd5, 4, 2'b11, 0);
        check_eq("count/full after delete", 32'({count, full}), 32'({5'd15, 1'b0}));
        do_req(2'b01, 8'h77, 2'b00, 4'd5, 4, 2'b11, 0);
        check_eq("count after refill", 32'({count, full}), 32'({5'd16, 1'b1}));
        do_req(2'b10, 8'h99, 2'b01, 4'd0, 3, 2'b01, 0);
        do_req(2'b00, 8'h77, 2'b00, 4'd5, 3, 2'b01, 0);

        do_req(2'b11, 8'h3C, 2'b11, 4'd0, 1, 2'b00, 0);
        do_req(2'b01, 8'hFF, 2'b11, 4'd0, 1, 2'b00, 5);
        check_eq("count after ERR", 32'(count), 32'(16));

        // Delete slot 0, then pull reset during its WRITE cycle.
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_key   = 8'h3C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !cam_wen; i++) begin
            @(posedge clk); #1;
        end
        check_eq("reached WRITE", 32'({cam_wen, cam_addr, cam_din}), 32'({1'b1, 4'd0, 8'hFF}));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("outputs after mid-write reset");
        rst_n = 1'b1;
        scrub_check();
        check_eq("no stale rsp", 32'(rsp_valid), 32'(0));
        do_req(2'b00, 8'h3C, 2'b01, 4'd0, 3, 2'b01, 0);
        do_req(2'b01, 8'hA5, 2'b00, 4'd0, 4, 2'b11, 0);
        check_eq("count after re-scrub insert", 32'(count), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
